// File: rtl/frame_buffer_arbiter.sv
// Shares one single-port pixel memory between a camera write stream and an HDMI read stream.
// Triple-buffered banks with round-robin burst arbitration; one idle cycle separates bursts.
module frame_buffer_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned BURST_LEN  = 16
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  input  logic [15:0]           resolution_width_i,
  input  logic [15:0]           resolution_depth_i,
  input  logic                  empty_i,
  input  logic                  full_i,
  output logic                  wr_pop_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  rd_push_o,
  output logic [1:0]            wr_bank_o,
  output logic [1:0]            rd_bank_o,
  output logic                  frame_wr_done_o,
  output logic                  frame_rd_done_o
);

  localparam int unsigned BeatW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BeatW-1:0] BeatLast = BeatW'(BURST_LEN - 1);

  if (BURST_LEN < 1 || DATA_WIDTH < 1) begin : g_bad_params
    $error("frame_buffer_arbiter: BURST_LEN and DATA_WIDTH must be at least 1");
  end

  typedef enum logic [1:0] {StIdle, StWrite, StRead} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wr_cnt_q, wr_cnt_d;
  logic [ADDR_WIDTH-1:0]   rd_cnt_q, rd_cnt_d;
  logic [BeatW-1:0]        beat_q, beat_d;
  logic [ADDR_WIDTH-1:0]   frame_size_q, frame_size_d;
  logic                    fs_valid_q;
  logic [1:0]              wr_bank_q, wr_bank_d;
  logic [1:0]              rd_bank_q, rd_bank_d;
  logic [1:0]              latest_q, latest_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    last_rd_q, last_rd_d;
  logic                    rd_push_q;

  logic [31:0]             fs_full;
  logic [ADDR_WIDTH-1:0]   fs_new;
  logic [ADDR_WIDTH-1:0]   wr_fs;
  logic                    wr_req, rd_req;
  logic                    wr_beat, rd_beat;
  logic                    fs_latch, wr_first;
  logic                    wr_last, rd_last;

  function automatic logic [ADDR_WIDTH-1:0] bank_base(input logic [1:0]            bank,
                                                      input logic [ADDR_WIDTH-1:0] fs);
    case (bank)
      2'd1:    bank_base = fs;
      2'd2:    bank_base = fs << 1;
      default: bank_base = '0;
    endcase
  endfunction

  // Lowest-numbered bank that is neither a nor b.
  function automatic logic [1:0] free_bank(input logic [1:0] a, input logic [1:0] b);
    if (a != 2'd0 && b != 2'd0) begin
      free_bank = 2'd0;
    end else if (a != 2'd1 && b != 2'd1) begin
      free_bank = 2'd1;
    end else begin
      free_bank = 2'd2;
    end
  endfunction

  assign fs_full = {16'd0, resolution_width_i} * {16'd0, resolution_depth_i};
  assign fs_new  = ADDR_WIDTH'(fs_full);

  assign wr_req   = !empty_i;
  assign rd_req   = rd_valid_q && !full_i;
  assign wr_beat  = (state_q == StWrite) && wr_req;
  assign rd_beat  = (state_q == StRead) && rd_req;
  assign wr_first = wr_beat && (wr_cnt_q == '0);
  assign fs_latch = !fs_valid_q || wr_first;
  // The first beat of a frame already uses the freshly latched size.
  assign wr_fs    = wr_first ? fs_new : frame_size_q;
  assign wr_last  = wr_beat && (wr_cnt_q == wr_fs - ADDR_WIDTH'(1));
  assign rd_last  = rd_beat && (rd_cnt_q == frame_size_q - ADDR_WIDTH'(1));

  always_comb begin
    mem_addr_o = '0;
    if (wr_beat) begin
      mem_addr_o = bank_base(wr_bank_q, wr_fs) + wr_cnt_q;
    end else if (rd_beat) begin
      mem_addr_o = bank_base(rd_bank_q, frame_size_q) + rd_cnt_q;
    end
  end

  assign mem_en_o        = wr_beat || rd_beat;
  assign mem_we_o        = wr_beat;
  assign wr_pop_o        = wr_beat;
  assign rd_push_o       = rd_push_q;
  assign wr_bank_o       = wr_bank_q;
  assign rd_bank_o       = rd_bank_q;
  assign frame_wr_done_o = wr_last;
  assign frame_rd_done_o = rd_last;

  // Bank rotation and frame bookkeeping.
  always_comb begin
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    frame_size_d = fs_latch ? fs_new : frame_size_q;
    rd_bank_d    = rd_bank_q;
    wr_bank_d    = wr_bank_q;
    latest_d     = latest_q;
    rd_valid_d   = rd_valid_q;

    if (wr_beat) begin
      wr_cnt_d = wr_last ? '0 : wr_cnt_q + ADDR_WIDTH'(1);
    end
    if (rd_beat) begin
      rd_cnt_d = rd_last ? '0 : rd_cnt_q + ADDR_WIDTH'(1);
    end

    // The very first completed frame goes straight to the display; nothing was being read.
    if (wr_last && (!rd_valid_q || rd_last)) begin
      rd_bank_d = wr_bank_q;
    end else if (rd_last) begin
      rd_bank_d = latest_q;
    end

    if (wr_last) begin
      latest_d   = wr_bank_q;
      rd_valid_d = 1'b1;
      wr_bank_d  = free_bank(wr_bank_q, rd_bank_d);
    end
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    last_rd_d = last_rd_q;
    unique case (state_q)
      StIdle: begin
        if (wr_req && rd_req) begin
          state_d = last_rd_q ? StWrite : StRead;
          beat_d  = '0;
        end else if (wr_req) begin
          state_d = StWrite;
          beat_d  = '0;
        end else if (rd_req) begin
          state_d = StRead;
          beat_d  = '0;
        end
      end
      StWrite: begin
        if (!wr_req || wr_last || beat_q == BeatLast) begin
          state_d   = StIdle;
          last_rd_d = 1'b0;
        end else begin
          beat_d = beat_q + BeatW'(1);
        end
      end
      StRead: begin
        if (!rd_req || rd_last || beat_q == BeatLast) begin
          state_d   = StIdle;
          last_rd_d = 1'b1;
        end else begin
          beat_d = beat_q + BeatW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q      <= StIdle;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      beat_q       <= '0;
      frame_size_q <= '0;
      fs_valid_q   <= 1'b0;
      wr_bank_q    <= 2'd0;
      rd_bank_q    <= 2'd2;
      latest_q     <= 2'd0;
      rd_valid_q   <= 1'b0;
      last_rd_q    <= 1'b1;
      rd_push_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      beat_q       <= beat_d;
      frame_size_q <= frame_size_d;
      fs_valid_q   <= 1'b1;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      latest_q     <= latest_d;
      rd_valid_q   <= rd_valid_d;
      last_rd_q    <= last_rd_d;
      rd_push_q    <= rd_beat;
    end
  end

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Randomized bench for frame_buffer_arbiter: a frame-level reference model predicts addresses,
// banks and done pulses; read issues queue expected push cycles that a monitor retires.
module tb_frame_buffer_arbiter;

  localparam int unsigned AW    = 32;
  localparam int unsigned BURST = 4;

  logic          clk_i = 1'b0;
  logic          resetn_i;
  logic [15:0]   resolution_width_i;
  logic [15:0]   resolution_depth_i;
  logic          empty_i;
  logic          full_i;
  logic          wr_pop_o;
  logic          mem_en_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic          rd_push_o;
  logic [1:0]    wr_bank_o;
  logic [1:0]    rd_bank_o;
  logic          frame_wr_done_o;
  logic          frame_rd_done_o;

  frame_buffer_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(16),
    .BURST_LEN (BURST)
  ) dut (
    .clk_i             (clk_i),
    .resetn_i          (resetn_i),
    .resolution_width_i(resolution_width_i),
    .resolution_depth_i(resolution_depth_i),
    .empty_i           (empty_i),
    .full_i            (full_i),
    .wr_pop_o          (wr_pop_o),
    .mem_en_o          (mem_en_o),
    .mem_we_o          (mem_we_o),
    .mem_addr_o        (mem_addr_o),
    .rd_push_o         (rd_push_o),
    .wr_bank_o         (wr_bank_o),
    .rd_bank_o         (rd_bank_o),
    .frame_wr_done_o   (frame_wr_done_o),
    .frame_rd_done_o   (frame_rd_done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int unsigned cyc;
    bit          we;
    int unsigned addr;
  } acc_t;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model state (frame-level view of the triple buffer).
  int unsigned m_fs, m_wr_pix, m_rd_pix, m_wr_bank, m_rd_bank, m_latest;
  bit          m_valid;
  int unsigned push_q[$];
  acc_t        log_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int unsigned mbase(input int unsigned b);
    return b * m_fs;
  endfunction

  function automatic int unsigned third(input int unsigned a, input int unsigned b);
    for (int unsigned k = 0; k < 3; k++) begin
      if (k != a && k != b) return k;
    end
    return 0;
  endfunction

  // Monitor: compares every cycle on the falling edge, then advances the model.
  initial begin : monitor
    int unsigned cyc = 0;
    int unsigned cur_beats = 0;
    int unsigned wr_wait = 0, rd_wait = 0;
    bit prev_acc = 0, prev_we = 0, prev_end = 0;
    bit wr_req, rd_req, wbeat, rbeat, w_end, r_end;
    int unsigned exp_addr, new_rd;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (!resetn_i) begin
        m_fs = resolution_width_i * resolution_depth_i;
        m_wr_pix = 0; m_rd_pix = 0; m_wr_bank = 0; m_rd_bank = 2; m_latest = 0; m_valid = 0;
        push_q.delete();
        log_q.delete();
        cur_beats = 0; wr_wait = 0; rd_wait = 0;
        prev_acc = 0; prev_we = 0; prev_end = 0;
      end else begin
        wr_req = !empty_i;
        rd_req = m_valid && !full_i;
        wbeat  = mem_en_o && mem_we_o;
        rbeat  = mem_en_o && !mem_we_o;

        if (push_q.size() > 0 && push_q[0] == cyc) begin
          chk("rd_push", rd_push_o, 1);
          void'(push_q.pop_front());
        end else begin
          chk("rd_push_idle", rd_push_o, 0);
        end
        chk("wr_bank", wr_bank_o, m_wr_bank);
        chk("rd_bank", rd_bank_o, m_rd_bank);
        chk("bank_distinct", wr_bank_o != rd_bank_o, 1);
        chk("wr_pop", wr_pop_o, wbeat);

        if (mem_en_o) begin
          chk(wbeat ? "wr_legal" : "rd_legal", wbeat ? wr_req : rd_req, 1);
          exp_addr = wbeat ? mbase(m_wr_bank) + m_wr_pix : mbase(m_rd_bank) + m_rd_pix;
          chk("mem_addr", mem_addr_o, exp_addr);
          if (prev_acc) begin
            chk("burst_side", wbeat, prev_we);
            chk("burst_len", cur_beats < BURST, 1);
            chk("frame_end_exit", prev_end, 0);
            cur_beats++;
          end else begin
            cur_beats = 1;
          end
          log_q.push_back('{cyc: cyc, we: wbeat, addr: mem_addr_o});
        end

        w_end = wbeat && (m_wr_pix == m_fs - 1);
        r_end = rbeat && (m_rd_pix == m_fs - 1);
        chk("wr_done", frame_wr_done_o, w_end);
        chk("rd_done", frame_rd_done_o, r_end);

        if (wr_req && !wbeat) wr_wait++; else wr_wait = 0;
        if (rd_req && !rbeat) rd_wait++; else rd_wait = 0;
        if (wr_req) chk("wr_starve", wr_wait <= BURST + 2, 1);
        if (rd_req) chk("rd_starve", rd_wait <= BURST + 2, 1);

        if (rbeat) begin
          push_q.push_back(cyc + 1);
          m_rd_pix = r_end ? 0 : m_rd_pix + 1;
        end
        if (wbeat) m_wr_pix = w_end ? 0 : m_wr_pix + 1;
        new_rd = m_rd_bank;
        if (w_end && (!m_valid || r_end)) new_rd = m_wr_bank;
        else if (r_end) new_rd = m_latest;
        if (w_end) begin
          m_latest  = m_wr_bank;
          m_valid   = 1;
          m_wr_bank = third(m_wr_bank, new_rd);
        end
        m_rd_bank = new_rd;

        prev_acc = mem_en_o;
        prev_we  = mem_we_o;
        prev_end = w_end || r_end;
      end
    end
  end

  task automatic do_reset(input int unsigned wv, input int unsigned dv, input bit e, input bit f);
    @(posedge clk_i);
    #1;
    resetn_i = 1'b0;
    resolution_width_i = 16'(wv);
    resolution_depth_i = 16'(dv);
    empty_i = e;
    full_i  = f;
    #1;
    chk("rst_mem_en", mem_en_o, 0);
    chk("rst_we", mem_we_o, 0);
    chk("rst_pop", wr_pop_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_push", rd_push_o, 0);
    chk("rst_wr_bank", wr_bank_o, 0);
    chk("rst_rd_bank", rd_bank_o, 2);
    chk("rst_done", {frame_wr_done_o, frame_rd_done_o}, 0);
    repeat (3) @(posedge clk_i);
    #1 resetn_i = 1'b1;
  endtask

  task automatic run_random(input int unsigned wv, input int unsigned dv, input int unsigned n,
                            input int unsigned pe, input int unsigned pf);
    do_reset(wv, dv, 1'b1, 1'b0);
    repeat (n) begin
      @(posedge clk_i);
      #1;
      empty_i = ($urandom_range(0, 99) < pe);
      full_i  = ($urandom_range(0, 99) < pf);
    end
  endtask

  // Both sides requesting from reset on a 4x2 frame: W W R W R W R bursts of 4 beats.
  task automatic check_directed();
    logic [6:0]  pat = 7'b0101011;
    int unsigned w_addr = 0, r_addr = 0, b, ea, ec;
    chk("dir_count", log_q.size() >= 28, 1);
    if (log_q.size() >= 28) begin
      for (int i = 0; i < 28; i++) begin
        b  = i / 4;
        ec = log_q[0].cyc + b * 5 + i % 4;
        if (pat[b]) begin
          ea = w_addr;
          w_addr++;
        end else begin
          ea = r_addr % 8;
          r_addr++;
        end
        chk("dir_side", log_q[i].we, pat[b]);
        chk("dir_addr", log_q[i].addr, ea);
        chk("dir_cycle", log_q[i].cyc, ec);
      end
    end
  endtask

  initial begin : stimulus
    bit found;
    resetn_i = 1'b0;
    resolution_width_i = 16'd4;
    resolution_depth_i = 16'd2;
    empty_i = 1'b1;
    full_i  = 1'b0;

    // Idle: nothing to write, nothing valid to read.
    do_reset(4, 2, 1'b1, 1'b0);
    repeat (10) @(posedge clk_i);

    do_reset(4, 2, 1'b0, 1'b0);
    repeat (40) @(posedge clk_i);
    check_directed();

    // Asynchronous reset in the middle of a write burst.
    do_reset(4, 2, 1'b0, 1'b0);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk_i);
      if (mem_en_o && mem_we_o && mem_addr_o == 5) found = 1;
    end
    chk("addr5_reached", found, 1);
    #1 resetn_i = 1'b0;
    #1;
    chk("arst_mem_en", mem_en_o, 0);
    chk("arst_pop", wr_pop_o, 0);
    chk("arst_addr", mem_addr_o, 0);
    chk("arst_wr_bank", wr_bank_o, 0);
    chk("arst_rd_bank", rd_bank_o, 2);
    repeat (3) @(posedge clk_i);
    #1 resetn_i = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk_i);
      if (mem_en_o) found = 1;
    end
    chk("restart_seen", found, 1);
    chk("restart_we", mem_we_o, 1);
    chk("restart_addr", mem_addr_o, 0);
    chk("restart_bank", wr_bank_o, 0);
    repeat (20) @(posedge clk_i);

    run_random(3, 3, 3000, 30, 25);
    run_random(5, 2, 2000, 15, 40);
    run_random(1, 1, 500, 40, 30);

    @(posedge clk_i);
    #1;
    empty_i = 1'b1;
    full_i  = 1'b1;
    repeat (5) @(posedge clk_i);
    chk("push_drain", push_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
